// File: rtl/sbp_lookup_pipe.sv
// sbp_lookup_pipe: pipelined SBP longest-prefix lookup over NUM_STAGES node RAMs.
// Each stage spends two cycles on a token: a registered port-A read, then a node decode.
// Port B of every RAM takes runtime table writes. A barrier write first drains the pipe.
// Optional statistics counters are compiled in when SBP_LOOKUP_STATS_EN is defined.
module sbp_lookup_pipe #(
  parameter int  NUM_STAGES    = 32,
  parameter int  KEY_BITS      = 32,
  parameter int  LOC_BITS      = 11,
  parameter int  STAGE_ID_BITS = 6,
  parameter int  RES_BITS      = 17,
  parameter int  TAG_BITS      = 8,
  localparam int BP_BITS       = $clog2(KEY_BITS),
  localparam int NODE_BITS     = 1 + RES_BITS + STAGE_ID_BITS + 2 * LOC_BITS + BP_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [KEY_BITS-1:0]      key_i,
  input  logic [TAG_BITS-1:0]      tag_i,
  output logic                     valid_o,
  output logic                     hit_o,
  output logic [RES_BITS-1:0]      result_o,
  output logic [TAG_BITS-1:0]      tag_o,
`ifdef SBP_LOOKUP_STATS_EN
  input  logic                     stat_clr_i,
  output logic [31:0]              stat_lookups_o,
  output logic [31:0]              stat_hits_o,
  output logic [31:0]              stat_upd_o,
`endif
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic                     upd_barrier_i,
  input  logic [STAGE_ID_BITS-1:0] upd_stage_i,
  input  logic [LOC_BITS-1:0]      upd_addr_i,
  input  logic [NODE_BITS-1:0]     upd_data_i
);

  localparam int IF_BITS = $clog2(2 * NUM_STAGES + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef struct packed {
    logic                     active;
    logic [KEY_BITS-1:0]      key;
    logic [TAG_BITS-1:0]      tag;
    logic [STAGE_ID_BITS-1:0] cur_stage;
    logic [LOC_BITS-1:0]      loc;
    logic [RES_BITS-1:0]      best_res;
    logic                     hit;
  } token_t;

  typedef struct packed {
    logic                     res_vld;
    logic [RES_BITS-1:0]      res;
    logic [STAGE_ID_BITS-1:0] nxt_stage;
    logic [LOC_BITS-1:0]      loc1;
    logic [LOC_BITS-1:0]      loc0;
    logic [BP_BITS-1:0]       bit_pos;
  } node_t;

  logic               out_en;
  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [IF_BITS-1:0] inflight;
  logic               accept;
  logic               retire;
  logic               upd_fire;
  token_t             ing_tok;

  // Stage-B (decode) registers form the inter-stage chain; the last one drives the outputs.
  logic               b_vld [NUM_STAGES];
  token_t             b_tok [NUM_STAGES];

  assign ready_o     = out_en && (state == ST_RUN);
  assign upd_ready_o = out_en && (((state == ST_RUN) && !upd_barrier_i) || (state == ST_WRITE));
  assign accept      = valid_i && ready_o;
  assign upd_fire    = upd_valid_i && upd_ready_o;
  assign retire      = b_vld[NUM_STAGES-1];

  // Fresh token for an accepted request: walk starts at stage 0, node 0, nothing matched yet.
  always_comb begin
    ing_tok           = '0;
    ing_tok.active    = 1'b1;
    ing_tok.key       = key_i;
    ing_tok.tag       = tag_i;
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic                 in_vld;
    token_t               in_tok;
    logic                 rd_en;
    logic                 wr_en;
    logic                 a_vld;
    logic                 a_rd;
    token_t               a_tok;
    token_t               nxt_tok;
    node_t                node;
    logic [NODE_BITS-1:0] ram [2**LOC_BITS];
    logic [NODE_BITS-1:0] rd_word;

    if (s == 0) begin : g_head
      assign in_vld = accept;
      assign in_tok = ing_tok;
    end else begin : g_link
      assign in_vld = b_vld[s-1];
      assign in_tok = b_tok[s-1];
    end

    assign rd_en = in_vld && in_tok.active && (int'(in_tok.cur_stage) == s);
    assign wr_en = upd_fire && (int'(upd_stage_i) == s);

    // Node RAM: port B write, port A registered read; a same-cycle hit returns the old word.
    // NOTE: the RAM has no reset -- table contents survive rst and are loaded through port B,
    // and the non-blocking assignments are what give read-first behaviour on a collision.
    always_ff @(posedge clk) begin
      if (wr_en) ram[upd_addr_i] <= upd_data_i;
      if (rd_en) rd_word <= ram[in_tok.loc];
    end

    // Cycle 1: capture the token alongside the RAM read it issued (if any).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_vld <= 1'b0;
        a_rd  <= 1'b0;
        a_tok <= '0;
      end else begin
        a_vld <= in_vld;
        a_rd  <= rd_en;
        a_tok <= in_tok;
      end
    end

    assign node = node_t'(rd_word);

    // Cycle 2: apply the node to a token that read it; everything else passes unchanged.
    // NOTE: nxt_tok is fully assigned before any branch, so no latch can be inferred.
    always_comb begin
      nxt_tok = a_tok;
      if (a_rd) begin
        if (node.res_vld) begin
          nxt_tok.best_res = node.res;
          nxt_tok.hit      = 1'b1;
        end
        nxt_tok.loc       = a_tok.key[node.bit_pos] ? node.loc1 : node.loc0;
        nxt_tok.cur_stage = node.nxt_stage;
        if ((int'(node.nxt_stage) <= s) || (int'(node.nxt_stage) >= NUM_STAGES)) begin
          nxt_tok.active = 1'b0;
        end
      end
    end

    // Decode register: hands the token to the next stage (or to the outputs).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        b_vld[s] <= 1'b0;
        b_tok[s] <= '0;
      end else begin
        b_vld[s] <= a_vld;
        b_tok[s] <= nxt_tok;
      end
    end
  end

  assign valid_o  = retire;
  assign hit_o    = retire && b_tok[NUM_STAGES-1].hit;
  assign result_o = retire ? b_tok[NUM_STAGES-1].best_res : '0;
  assign tag_o    = retire ? b_tok[NUM_STAGES-1].tag : '0;

  // Ingress is held off during reset and opens on the first edge after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_en <= 1'b0;
    else     out_en <= 1'b1;
  end

  // In-flight lookup count: accepted but not yet retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (accept && !retire && (inflight != '1)) begin
      inflight <= inflight + IF_BITS'(1);
    end else if (!accept && retire && (inflight != '0)) begin
      inflight <= inflight - IF_BITS'(1);
    end
  end

  // Update FSM next state: barrier writes wait in DRAIN until the pipe is empty.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (out_en && upd_valid_i && upd_barrier_i) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight == '0) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Update FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

`ifdef SBP_LOOKUP_STATS_EN
  logic        upd_commit;
  logic [31:0] n_lookups;
  logic [31:0] n_hits;
  logic [31:0] n_upd;

  assign upd_commit = upd_fire && (int'(upd_stage_i) < NUM_STAGES);

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lookups <= '0;
      n_hits    <= '0;
      n_upd     <= '0;
    end else if (stat_clr_i) begin
      n_lookups <= '0;
      n_hits    <= '0;
      n_upd     <= '0;
    end else begin
      if (retire && (n_lookups != '1))          n_lookups <= n_lookups + 32'd1;
      if (retire && hit_o && (n_hits != '1))    n_hits    <= n_hits + 32'd1;
      if (upd_commit && (n_upd != '1))          n_upd     <= n_upd + 32'd1;
    end
  end

  assign stat_lookups_o = n_lookups;
  assign stat_hits_o    = n_hits;
  assign stat_upd_o     = n_upd;
`endif

endmodule

// File: tb/tb_sbp_lookup_pipe.sv
// tb_sbp_lookup_pipe: scoreboard bench for sbp_lookup_pipe with NUM_STAGES=4.
// Expected results come from a walk over a bench-side copy of the node tables.
module tb_sbp_lookup_pipe;
  localparam int N         = 4;
  localparam int KEY_BITS  = 32;
  localparam int LOC_BITS  = 11;
  localparam int SID_BITS  = 6;
  localparam int RES_BITS  = 17;
  localparam int TAG_BITS  = 8;
  localparam int BP_BITS   = 5;
  localparam int NODE_BITS = 1 + RES_BITS + SID_BITS + 2 * LOC_BITS + BP_BITS;
  localparam int NADDR     = 8;

  typedef struct {
    logic [TAG_BITS-1:0] tag;
    logic                hit;
    logic [RES_BITS-1:0] res;
    int                  acc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_i = 1'b0;
  logic                 ready_o;
  logic [KEY_BITS-1:0]  key_i = '0;
  logic [TAG_BITS-1:0]  tag_i = '0;
  logic                 valid_o;
  logic                 hit_o;
  logic [RES_BITS-1:0]  result_o;
  logic [TAG_BITS-1:0]  tag_o;
  logic                 upd_valid_i = 1'b0;
  logic                 upd_ready_o;
  logic                 upd_barrier_i = 1'b0;
  logic [SID_BITS-1:0]  upd_stage_i = '0;
  logic [LOC_BITS-1:0]  upd_addr_i = '0;
  logic [NODE_BITS-1:0] upd_data_i = '0;
`ifdef SBP_LOOKUP_STATS_EN
  logic                 stat_clr_i = 1'b0;
  logic [31:0]          stat_lookups_o;
  logic [31:0]          stat_hits_o;
  logic [31:0]          stat_upd_o;
`endif

  sbp_lookup_pipe #(.NUM_STAGES(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .key_i         (key_i),
    .tag_i         (tag_i),
    .valid_o       (valid_o),
    .hit_o         (hit_o),
    .result_o      (result_o),
    .tag_o         (tag_o),
`ifdef SBP_LOOKUP_STATS_EN
    .stat_clr_i    (stat_clr_i),
    .stat_lookups_o(stat_lookups_o),
    .stat_hits_o   (stat_hits_o),
    .stat_upd_o    (stat_upd_o),
`endif
    .upd_valid_i   (upd_valid_i),
    .upd_ready_o   (upd_ready_o),
    .upd_barrier_i (upd_barrier_i),
    .upd_stage_i   (upd_stage_i),
    .upd_addr_i    (upd_addr_i),
    .upd_data_i    (upd_data_i)
  );

  always #5 clk = ~clk;

  int                   cyc = 0;
  int                   n_cmp = 0;
  int                   n_fail = 0;
  int                   n_out = 0;
  int                   last_valid = 0;
  int                   last_acc = 0;
  exp_t                 sbq [$];
  logic [NODE_BITS-1:0] mem [N][NADDR];
  logic [RES_BITS-1:0]  res_by_tag [256];
  logic                 hit_by_tag [256];
  bit                   ready_log [4096];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NODE_BITS-1:0] mk_node(input bit vld, input int res, input int nxt,
                                                   input int loc1, input int loc0, input int bp);
    logic [RES_BITS-1:0] r;
    logic [SID_BITS-1:0] n;
    logic [LOC_BITS-1:0] l1;
    logic [LOC_BITS-1:0] l0;
    logic [BP_BITS-1:0]  b;
    r  = RES_BITS'(res);
    n  = SID_BITS'(nxt);
    l1 = LOC_BITS'(loc1);
    l0 = LOC_BITS'(loc0);
    b  = BP_BITS'(bp);
    return {vld, r, n, l1, l0, b};
  endfunction

  function automatic logic [NODE_BITS-1:0] rand_node();
    return mk_node(1'($urandom_range(0, 1)), int'($urandom_range(0, 131071)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, NADDR - 1)),
                   int'($urandom_range(0, NADDR - 1)), int'($urandom_range(0, 31)));
  endfunction

  // Reference: walk the table from stage 0 node 0, remembering the deepest matching result.
  function automatic exp_t ref_walk(input logic [KEY_BITS-1:0] key, input logic [TAG_BITS-1:0] tag);
    exp_t                e;
    int                  s;
    int                  loc;
    bit                  done;
    logic                vld;
    logic [RES_BITS-1:0] res;
    logic [SID_BITS-1:0] nxt;
    logic [LOC_BITS-1:0] l1;
    logic [LOC_BITS-1:0] l0;
    logic [BP_BITS-1:0]  bp;
    e.tag = tag; e.hit = 1'b0; e.res = '0; e.acc = 0;
    s = 0; loc = 0; done = 1'b0;
    for (int step = 0; step < N; step++) begin
      if (!done) begin
        {vld, res, nxt, l1, l0, bp} = mem[s][loc];
        if (vld) begin
          e.hit = 1'b1;
          e.res = res;
        end
        loc = key[bp] ? int'(l1) : int'(l0);
        if (int'(nxt) <= s || int'(nxt) >= N) done = 1'b1;
        else s = int'(nxt);
      end
    end
    return e;
  endfunction

  // Monitor and ingress model, both sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      ready_log[cyc % 4096] = ready_o;
      if (valid_o) begin
        n_out++;
        last_valid = cyc;
        res_by_tag[tag_o] = result_o;
        hit_by_tag[tag_o] = hit_o;
        if (sbq.size() == 0) begin
          check("unexpected_valid_o", 64'(tag_o), 64'hFFFF);
        end else begin
          e = sbq.pop_front();
          check("tag_order", 64'(tag_o), 64'(e.tag));
          check("hit", 64'(hit_o), 64'(e.hit));
          check("result", 64'(result_o), 64'(e.res));
          check("latency", 64'(cyc - e.acc), 64'(2 * N));
        end
      end
      if (valid_i && ready_o) begin
        e = ref_walk(key_i, tag_i);
        e.acc = cyc;
        last_acc = cyc;
        sbq.push_back(e);
      end
      if (upd_valid_i && upd_ready_o && (int'(upd_stage_i) < N) && (int'(upd_addr_i) < NADDR)) begin
        mem[upd_stage_i][upd_addr_i] = upd_data_i;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [KEY_BITS-1:0] key, input logic [TAG_BITS-1:0] tag);
    bit acc;
    int n;
    valid_i = 1'b1; key_i = key; tag_i = tag; acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ready_o;
      n++;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic upd(input int stage, input int addr, input logic [NODE_BITS-1:0] data,
                     input bit barrier, output int start_c, output int acc_c);
    bit acc;
    int n;
    upd_valid_i = 1'b1; upd_barrier_i = barrier; upd_stage_i = SID_BITS'(stage);
    upd_addr_i = LOC_BITS'(addr); upd_data_i = data;
    acc = 1'b0; n = 0; start_c = -1; acc_c = -1;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (start_c < 0) start_c = cyc;
      acc = upd_ready_o;
      if (acc) acc_c = cyc;
      n++;
      @(posedge clk);
      #1;
    end
    upd_valid_i = 1'b0; upd_barrier_i = 1'b0;
    if (!acc) check("upd_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    if (sbq.size() != 0) check("drain_timeout", 64'(sbq.size()), 64'd0);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int ac;
    int c0;
    int out0;
    for (int s = 0; s < N; s++)
      for (int a = 0; a < NADDR; a++) mem[s][a] = '0;
    for (int t = 0; t < 256; t++) begin
      res_by_tag[t] = '1;
      hit_by_tag[t] = 1'b1;
    end

    // Reset state.
    tick(3);
    @(negedge clk);
    check("rst_ready_o", 64'(ready_o), 64'd0);
    check("rst_upd_ready_o", 64'(upd_ready_o), 64'd0);
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_hit_o", 64'(hit_o), 64'd0);
    check("rst_result_o", 64'(result_o), 64'd0);
    check("rst_tag_o", 64'(tag_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_edge", 64'(ready_o), 64'd0);
    @(negedge clk);
    check("ready_after_first_edge", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;

    // Zero the node words the bench uses.
    for (int s = 0; s < N; s++)
      for (int a = 0; a < NADDR; a++) upd(s, a, '0, 1'b0, st, ac);

    // Empty tables: miss, tag passthrough.
    send(32'h0A00_0001, 8'h5A);
    wait_drain();
    check("t1_hit", 64'(hit_by_tag[8'h5A]), 64'd0);
    check("t1_result", 64'(res_by_tag[8'h5A]), 64'd0);

    // Two-level walk: bit 31 selects loc1 into stage 2.
    upd(0, 0, mk_node(1'b1, 1, 2, 3, 0, 31), 1'b0, st, ac);
    upd(2, 3, mk_node(1'b1, 2, 0, 0, 0, 0), 1'b0, st, ac);
    send(32'h8000_0000, 8'd1);
    send(32'h0000_0000, 8'd2);
    wait_drain();
    check("t2_deep_hit", 64'(hit_by_tag[1]), 64'd1);
    check("t2_deep_result", 64'(res_by_tag[1]), 64'h2);
    check("t2_shallow_hit", 64'(hit_by_tag[2]), 64'd1);
    check("t2_shallow_result", 64'(res_by_tag[2]), 64'h1);

    // 20 back-to-back lookups.
    out0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 20; i++) send($urandom, 8'(i));
    check("b2b_accept_cycles", 64'(cyc - c0), 64'd20);
    wait_drain();
    check("b2b_outputs", 64'(n_out - out0), 64'd20);

    // Barrier write with 5 lookups in flight; a lookup waits behind it.
    for (int i = 0; i < 5; i++) send($urandom, 8'(100 + i));
    fork
      upd(0, 0, mk_node(1'b1, 17'h1ABC, 0, 0, 0, 0), 1'b1, st, ac);
      begin
        tick(1);
        send(32'h0, 8'd200);
      end
    join
    check("barrier_after_last_valid", 64'(ac - last_valid), 64'd2);
    check("lookup_after_barrier", 64'(last_acc - ac), 64'd1);
    for (int c = st + 1; c <= ac; c++) check("ready_low_in_drain", 64'(ready_log[c % 4096]), 64'd0);
    wait_drain();
    check("barrier_new_node", 64'(res_by_tag[200]), 64'h1ABC);

    // Barrier write with an empty pipe.
    upd(1, 2, mk_node(1'b1, 77, 3, 1, 1, 4), 1'b1, st, ac);
    check("barrier_empty_latency", 64'(ac - st), 64'd2);

    // Same-cycle write and read of stage 0 node 0: read-first.
    upd(0, 0, mk_node(1'b1, 5, 0, 0, 0, 0), 1'b0, st, ac);
    fork
      send(32'h0, 8'd50);
      upd(0, 0, mk_node(1'b1, 6, 0, 0, 0, 0), 1'b0, st, ac);
    join
    send(32'h0, 8'd51);
    wait_drain();
    check("read_first_old", 64'(res_by_tag[50]), 64'd5);
    check("read_first_new", 64'(res_by_tag[51]), 64'd6);

    // Out-of-range stage writes are accepted and discarded.
    upd(N, 0, mk_node(1'b1, 9, 0, 0, 0, 0), 1'b0, st, ac);
    upd(63, 0, mk_node(1'b1, 9, 0, 0, 0, 0), 1'b1, st, ac);
    send(32'h0, 8'd52);
    wait_drain();
    check("oob_write_ignored", 64'(res_by_tag[52]), 64'd6);

    // Reset mid-walk: in-flight lookups vanish, a fresh one completes.
    for (int i = 0; i < 3; i++) send($urandom, 8'(60 + i));
    tick(1);
    rst = 1'b1;
    sbq.delete();
    tick(2);
    rst = 1'b0;
    out0 = n_out;
    tick(1);
    send(32'h0, 8'd63);
    wait_drain();
    check("post_rst_outputs", 64'(n_out - out0), 64'd1);
    check("post_rst_result", 64'(res_by_tag[63]), 64'd6);
`ifdef SBP_LOOKUP_STATS_EN
    check("stat_lookups_after_rst", 64'(stat_lookups_o), 64'd1);
`endif

    // Randomised traffic with interleaved table updates.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)      send($urandom, 8'($urandom));
      else if (r < 85) upd(0, int'($urandom_range(0, NADDR - 1)), rand_node(), 1'b0, st, ac);
      else if (r < 95) upd(int'($urandom_range(0, N - 1)), int'($urandom_range(0, NADDR - 1)),
                           rand_node(), 1'b1, st, ac);
      else             upd(int'($urandom_range(N, 63)), int'($urandom_range(0, NADDR - 1)),
                           rand_node(), 1'($urandom_range(0, 1)), st, ac);
    end
    wait_drain();
    tick(2 * N);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
